id_operand_stage: RTL and testbench

- Parametrised decode/operand-fetch stage for the in-order RISC-V pipeline. It sits between instruction decode and EX.
- Holds the integer register file and resolves operand forwarding from a configurable number of downstream stages.
- Detects use-before-ready hazards and inserts bubbles. Registers the operands into EX through a valid/ready pipeline register that supports flush.

---
 rtl/id_operand_stage.sv | 165 ++++++++++++++++
 tb/tb_id_operand_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: register file, forwarding, hazard stall
// and the valid/ready pipeline register feeding EX.
module id_operand_stage #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NFWD  = 3,
    parameter int CTRLW = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [AW-1:0]        in_rs1,
    input  logic [AW-1:0]        in_rs2,
    input  logic                 in_rs1_used,
    input  logic                 in_rs2_used,
    input  logic [AW-1:0]        in_rd,
    input  logic                 in_reg_w_en,
    input  logic [1:0]           in_src1_sel,
    input  logic [1:0]           in_src2_sel,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [CTRLW-1:0]     in_ctrl,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_pending,
    input  logic [NFWD*AW-1:0]   fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_src_a,
    output logic [XLEN-1:0]      out_src_b,
    output logic [XLEN-1:0]      out_rs2_data,
    output logic [AW-1:0]        out_rd,
    output logic                 out_reg_w_en,
    output logic [CTRLW-1:0]     out_ctrl,
    output logic [31:0]          stall_count
);

    logic [XLEN-1:0] regs [NREGS];

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            rs1_pend;
    logic            rs2_pend;
    logic            hazard;
    logic            advance;
    logic            accept;

    // Lowest-index forwarding match wins; the descending scan lets it
    // overwrite older matches and the write-through bypass.
    function automatic void resolve(
        input  logic [AW-1:0]        rs,
        input  logic [XLEN-1:0]      rf_val,
        input  logic [NFWD-1:0]      fv,
        input  logic [NFWD-1:0]      fp,
        input  logic [NFWD*AW-1:0]   fr,
        input  logic [NFWD*XLEN-1:0] fd,
        input  logic                 we,
        input  logic [AW-1:0]        wa,
        input  logic [XLEN-1:0]      wd,
        output logic [XLEN-1:0]      val,
        output logic                 pend
    );
        val  = rf_val;
        pend = 1'b0;
        if (we && wa == rs)
            val = wd;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fv[i] && fr[i*AW +: AW] == rs) begin
                val  = fd[i*XLEN +: XLEN];
                pend = fp[i];
            end
        end
        if (rs == '0) begin
            val  = '0;
            pend = 1'b0;
        end
    endfunction

    always_comb begin
        resolve(in_rs1, regs[in_rs1], fwd_valid, fwd_pending, fwd_rd,
                fwd_data, wb_en, wb_addr, wb_data, rs1_val, rs1_pend);
        resolve(in_rs2, regs[in_rs2], fwd_valid, fwd_pending, fwd_rd,
                fwd_data, wb_en, wb_addr, wb_data, rs2_val, rs2_pend);
    end

    always_comb begin
        src_a = '0;
        unique case (in_src1_sel)
            2'd0:    src_a = rs1_val;
            2'd1:    src_a = in_pc;
            default: src_a = '0;
        endcase
    end

    always_comb begin
        src_b = '0;
        unique case (in_src2_sel)
            2'd0:    src_b = rs2_val;
            2'd1:    src_b = in_imm;
            2'd2:    src_b = XLEN'(4);
            default: src_b = '0;
        endcase
    end

    assign hazard   = in_valid && ((in_rs1_used && rs1_pend) ||
                                   (in_rs2_used && rs2_pend));
    assign advance  = !out_valid || out_ready;
    assign in_ready = flush || (advance && !hazard);
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_src_a    <= '0;
            out_src_b    <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
            out_reg_w_en <= 1'b0;
            out_ctrl     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_src_a    <= src_a;
            out_src_b    <= src_b;
            out_rs2_data <= rs2_val;
            out_rd       <= in_rd;
            out_reg_w_en <= in_reg_w_en;
            out_ctrl     <= in_ctrl;
        end else if (advance) begin
            // Bubble: clear side-effect bits so EX never acts on it.
            out_valid    <= 1'b0;
            out_reg_w_en <= 1'b0;
            out_ctrl     <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (hazard && !flush && stall_count != '1)
            stall_count <= stall_count + 32'd1;
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomized bench for id_operand_stage against a spec-level model
// of register file, forwarding priority and output register.
module tb_id_operand_stage;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NFWD  = 3;
    localparam int CTRLW = 16;
    localparam int AW    = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [AW-1:0]     in_rs1;
    logic [AW-1:0]     in_rs2;
    logic              in_rs1_used;
    logic              in_rs2_used;
    logic [AW-1:0]     in_rd;
    logic              in_reg_w_en;
    logic [1:0]        in_src1_sel;
    logic [1:0]        in_src2_sel;
    logic [XLEN-1:0]   in_imm;
    logic [CTRLW-1:0]  in_ctrl;
    logic [NFWD-1:0]   fwd_valid;
    logic [NFWD-1:0]   fwd_pending;
    logic [AW-1:0]     f_rd [NFWD];
    logic [XLEN-1:0]   f_data [NFWD];
    logic [NFWD*AW-1:0]   fwd_rd;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_src_a;
    logic [XLEN-1:0]   out_src_b;
    logic [XLEN-1:0]   out_rs2_data;
    logic [AW-1:0]     out_rd;
    logic              out_reg_w_en;
    logic [CTRLW-1:0]  out_ctrl;
    logic [31:0]       stall_count;

    assign fwd_rd   = {f_rd[2], f_rd[1], f_rd[0]};
    assign fwd_data = {f_data[2], f_data[1], f_data[0]};

    always #5 clk = ~clk;

    id_operand_stage #(
        .XLEN(XLEN), .NREGS(NREGS), .NFWD(NFWD), .CTRLW(CTRLW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
        .in_rd(in_rd), .in_reg_w_en(in_reg_w_en),
        .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
        .in_imm(in_imm), .in_ctrl(in_ctrl),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_src_a(out_src_a), .out_src_b(out_src_b),
        .out_rs2_data(out_rs2_data), .out_rd(out_rd),
        .out_reg_w_en(out_reg_w_en), .out_ctrl(out_ctrl),
        .stall_count(stall_count)
    );

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0]  m_rf [NREGS];
    logic             m_valid;
    logic [XLEN-1:0]  m_pc, m_a, m_b, m_rs2;
    logic [AW-1:0]    m_rd;
    logic             m_we;
    logic [CTRLW-1:0] m_ctrl;
    logic [31:0]      m_stall;
    logic             last_ready;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_read(input logic [AW-1:0] rs,
                                     output logic [XLEN-1:0] v,
                                     output bit pend);
        pend = 0;
        v    = '0;
        if (rs == 0) return;
        for (int i = 0; i < NFWD; i++) begin
            if (fwd_valid[i] && f_rd[i] == rs) begin
                v    = f_data[i];
                pend = fwd_pending[i];
                return;
            end
        end
        if (wb_en && wb_addr == rs) v = wb_data;
        else v = m_rf[rs];
    endfunction

    task automatic idle();
        in_valid = 0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
        in_rs1_used = 0; in_rs2_used = 0; in_rd = '0;
        in_reg_w_en = 0; in_src1_sel = '0; in_src2_sel = '0;
        in_imm = '0; in_ctrl = '0;
        fwd_valid = '0; fwd_pending = '0;
        for (int i = 0; i < NFWD; i++) begin
            f_rd[i] = '0; f_data[i] = '0;
        end
        wb_en = 0; wb_addr = '0; wb_data = '0;
        flush = 0; out_ready = 1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
        m_valid = 0; m_pc = '0; m_a = '0; m_b = '0; m_rs2 = '0;
        m_rd = '0; m_we = 0; m_ctrl = '0; m_stall = '0;
    endtask

    // Called with inputs driven just after a negedge.
    task automatic cycle();
        logic [XLEN-1:0] r1, r2, ea, eb;
        bit p1, p2, hz, adv, rdy, acc;
        #1;
        ref_read(in_rs1, r1, p1);
        ref_read(in_rs2, r2, p2);
        hz  = in_valid && ((in_rs1_used && p1) || (in_rs2_used && p2));
        adv = !m_valid || out_ready;
        rdy = flush || (adv && !hz);
        acc = in_valid && rdy && !flush;
        case (in_src1_sel)
            2'd0: ea = r1;
            2'd1: ea = in_pc;
            default: ea = '0;
        endcase
        case (in_src2_sel)
            2'd0: eb = r2;
            2'd1: eb = in_imm;
            2'd2: eb = 64'd4;
            default: eb = '0;
        endcase
        last_ready = in_ready;
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (flush) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_pc = in_pc; m_a = ea; m_b = eb; m_rs2 = r2;
            m_rd = in_rd; m_we = in_reg_w_en; m_ctrl = in_ctrl;
        end else if (adv) begin
            m_valid = 0; m_we = 0; m_ctrl = '0;
        end
        if (hz && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_pc", out_pc, m_pc);
        chk("out_src_a", out_src_a, m_a);
        chk("out_src_b", out_src_b, m_b);
        chk("out_rs2_data", out_rs2_data, m_rs2);
        chk("out_rd", out_rd, m_rd);
        chk("out_reg_w_en", out_reg_w_en, m_we);
        chk("out_ctrl", out_ctrl, m_ctrl);
        chk("stall_count", stall_count, m_stall);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0]     s0;
        logic [XLEN-1:0] hold_pc;
        idle();
        reset = 1;
        wb_en = 1; wb_addr = 5'd3; wb_data = 64'hDEAD;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        model_clear();
        @(negedge clk);
        idle();
        chk("rst_valid", out_valid, 0);
        chk("rst_src_a", out_src_a, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_stall", stall_count, 0);

        // Write-port then a read of x5; x0 write must be ignored.
        wb_en = 1; wb_addr = 5; wb_data = 64'h1234; cycle();
        wb_addr = 0; wb_data = 64'hFFFF; cycle();
        idle();
        in_valid = 1; in_rs1 = 5; in_rs2 = 0;
        in_rs1_used = 1; in_rs2_used = 1; in_pc = 64'h100;
        cycle();
        chk("tp1_valid", out_valid, 1);
        chk("tp1_a", out_src_a, 64'h1234);
        chk("tp1_b", out_src_b, 0);

        // Reset must have beaten the simultaneous x3 write.
        in_rs1 = 3; cycle();
        chk("rst_x3", out_src_a, 0);

        // Youngest forwarding source wins.
        idle();
        in_valid = 1; in_rs1 = 7; in_rs1_used = 1;
        fwd_valid = 3'b011; f_rd[0] = 7; f_rd[1] = 7;
        f_data[0] = 64'hAA; f_data[1] = 64'hBB;
        cycle();
        chk("tp2_a", out_src_a, 64'hAA);

        // Pending load on rs2 for two cycles.
        idle();
        s0 = stall_count;
        in_valid = 1; in_rs2 = 9; in_rs2_used = 1; in_reg_w_en = 1;
        in_ctrl = 16'h5A5A;
        fwd_valid = 3'b001; fwd_pending = 3'b001; f_rd[0] = 9;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("tp3_ready", last_ready, 0);
            chk("tp3_bub_v", out_valid, 0);
            chk("tp3_bub_we", out_reg_w_en, 0);
        end
        chk("tp3_stall", stall_count, s0 + 2);
        fwd_pending = 3'b000; f_data[0] = 64'h55;
        cycle();
        chk("tp3_ready2", last_ready, 1);
        chk("tp3_rs2", out_rs2_data, 64'h55);

        // Pending match on an unused rs2 must not stall.
        fwd_pending = 3'b001;
        in_rs2_used = 0; in_src2_sel = 1; in_imm = -64'sd4;
        cycle();
        chk("tp4_ready", last_ready, 1);
        chk("tp4_b", out_src_b, 64'hFFFF_FFFF_FFFF_FFFC);

        // Back-pressure from EX holds the output register.
        idle();
        in_valid = 1; in_pc = 64'h200; cycle();
        hold_pc = out_pc;
        out_ready = 0; in_pc = 64'h204;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("tp5_ready", last_ready, 0);
            chk("tp5_hold", out_pc, hold_pc);
        end
        out_ready = 1; cycle();
        chk("tp5_load", out_pc, 64'h204);

        // Flush while hazarded and holding a valid output.
        s0 = stall_count;
        in_rs1 = 4; in_rs1_used = 1;
        fwd_valid = 3'b100; fwd_pending = 3'b100; f_rd[2] = 4;
        flush = 1; out_ready = 0;
        cycle();
        chk("tp6_ready", last_ready, 1);
        chk("tp6_valid", out_valid, 0);
        chk("tp6_stall", stall_count, s0);

        for (int n = 0; n < 3000; n++) begin
            in_valid    = ($urandom_range(3) != 0);
            in_pc       = {$urandom, $urandom};
            in_rs1      = AW'($urandom_range(7));
            in_rs2      = AW'($urandom_range(7));
            in_rs1_used = $urandom_range(1);
            in_rs2_used = $urandom_range(1);
            in_rd       = AW'($urandom);
            in_reg_w_en = $urandom_range(1);
            in_src1_sel = 2'($urandom);
            in_src2_sel = 2'($urandom);
            in_imm      = {$urandom, $urandom};
            in_ctrl     = CTRLW'($urandom);
            fwd_valid   = NFWD'($urandom);
            for (int i = 0; i < NFWD; i++) begin
                fwd_pending[i] = ($urandom_range(3) == 0);
                f_rd[i]   = AW'($urandom_range(7));
                f_data[i] = {$urandom, $urandom};
            end
            wb_en     = $urandom_range(1);
            wb_addr   = AW'($urandom_range(7));
            wb_data   = {$urandom, $urandom};
            flush     = ($urandom_range(15) == 0);
            out_ready = ($urandom_range(9) < 7);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
